decode_pipe: RTL
================

# decode_pipe

Pipelined RV32 decode stage with parametrised register file, ID/EX pipeline register, write-back bypass and load-use hazard detection. Sits between the fetch stage (IF/ID outputs) and the execute stage. Instruction decode uses the team's `control_unit` and `sign_extend`. The register file and the ID/EX register are owned here.

## Interface
- DATA_WIDTH, 32, datapath width.
- REG_COUNT, 32, architectural registers; 16 (RV32E) or 32 only.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  IF/ID holds a real instruction
- if_instr  in  32  instruction word
- if_pc  in  DATA_WIDTH  PC of if_instr
- ex_stall  in  1  downstream stall; hold ID/EX unchanged
- ex_flush  in  1  taken branch/jump in execute; kill ID/EX content
- wb_en  in  1  write-back enable
- wb_addr  in  5  write-back register index
- wb_data  in  DATA_WIDTH  write-back data
- hazard_stall  out  1  combinational; fetch must hold IF/ID and PC
- id_valid  out  1  ID/EX holds a live instruction
- id_pc  out  DATA_WIDTH  registered PC
- id_rs1, id_rs2, id_rd  out  5 each  registered register indices
- id_rs1_data, id_rs2_data  out  DATA_WIDTH  registered operands
- id_imm  out  DATA_WIDTH  registered extended immediate
- id_funct3  out  3  registered instr[14:12]
- id_reg_write, id_mem_write, id_branch, id_jump  out  1 each  registered control
- id_result_src, id_pc_target_src, id_mem_size  out  2 each  registered control
- id_alu_control  out  4  registered ALU op
- id_alu_src_a, id_alu_src_b, id_mem_unsigned  out  1 each  registered control

## Operation
- Register file: REG_COUNT x DATA_WIDTH. x0 reads 0. Writes to x0 are ignored.
- Indices >= REG_COUNT read 0. Writes to those indices are dropped.
- Write occurs on the clk edge when wb_en=1.
- Write-through bypass: if wb_en=1, wb_addr!=0 and wb_addr equals a read index, that read returns wb_data in the same cycle.
- The `control_unit` alu_zero input is tied 0. Branch resolution is done in execute.
- id_branch = (opcode==1100011). id_jump = (opcode==1101111 or 1100111).
- Load-use hazard:
  - hazard_stall = if_valid & id_valid & id_reg_write & (id_result_src==2'b01) & (id_rd!=0) & (id_rd==if_instr[19:15] | id_rd==if_instr[24:20]).
  - The rs2 match counts only for R, S and B formats. The rs1 match is excluded for LUI, AUIPC and JAL.
- ID/EX update priority at each edge:
  1. rst: all id_* cleared to 0.
  2. ex_flush: bubble (id_valid=0, all control outputs 0). Other fields are don't-care, but the implementation clears them.
  3. ex_stall: hold all id_*.
  4. hazard_stall: insert bubble.
  5. Otherwise load decoded values, with id_valid = if_valid.
- When if_valid=0, the loaded control outputs are forced to 0, so no spurious write or store occurs.
- hazard_stall is gated low when ex_stall=1 or ex_flush=1.

## Timing
- Latency: if_* sampled at edge N appears on id_* after edge N.
- A load followed by a dependent instruction costs exactly one bubble cycle. hazard_stall is high for one cycle only.
- Reset: every output is 0 from the first edge with rst=1. Register file contents are 0.
- A reset asserted mid-stall or mid-hazard overrides everything.
- A write-back issued in the same cycle as rst is discarded.
- ex_flush together with ex_stall: flush wins.
- A write-back whose index equals a read index in the same cycle: the new value is captured into ID/EX (bypass).

## Test plan
- Reset: rst=1 for 2 cycles, then read x1..x31 → all id_rs*_data=0 and id_valid=0 throughout reset.
- Bypass: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF, with if_instr=add x6,x5,x5 in the same cycle → next cycle id_rs1_data=id_rs2_data=0xDEADBEEF. Writing x0=0x1234 then reading x0 → 0.
- Load-use: lw x3,0(x2) followed by add x4,x3,x1 → hazard_stall=1 for one cycle, one bubble (id_valid=0), then the add appears with id_rs1=3. Repeat with rd=x0 → no stall.
- Flush and stall priority:
  - ex_stall=1 for 3 cycles → id_* frozen.
  - ex_flush=1 together with ex_stall=1 → id_valid=0 and id_reg_write=0 next cycle.
- REG_COUNT=16: write x20=0xFF, read x20 → 0. Write x15=0xAA, read x15 → 0xAA.
- Decode spot-check: beq x1,x2,-8 → id_branch=1, id_imm=0xFFFFFFF8, id_funct3=000, id_reg_write=0. jalr → id_jump=1.

Source files
------------

// File: rtl/decode_pipe.sv
// ---------------------------------------------------------------------------
// decode_pipe -- RV32 decode stage.
//
// Decodes the instruction held in IF/ID, reads two operands from the
// register file (with write-through bypass from write-back), detects
// load-use hazards and registers everything into the ID/EX pipeline
// register.
//
// Files contents:
//   sign_extend   : immediate extraction and sign extension
//   control_unit  : opcode/funct decode into datapath control
//   decode_pipe   : register file, hazard logic, ID/EX register (top)
//
// decode_pipe ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_valid/if_instr/if_pc  IF/ID contents
//   ex_stall, ex_flush       execute-side hold / kill of ID/EX
//   wb_en/wb_addr/wb_data    register file write port
//   hazard_stall             combinational load-use stall to fetch
//   id_*                     registered ID/EX contents
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// sign_extend -- builds the immediate selected by imm_src_i and sign-extends
// it to DATA_WIDTH.
//   instr_i   : instruction bits [31:7]
//   imm_src_i : 000 I, 001 S, 010 B, 011 J, 100 U
//   imm_o     : extended immediate
// ---------------------------------------------------------------------------
module sign_extend #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:7]           instr_i,
  input  logic [2:0]            imm_src_i,
  output logic [DATA_WIDTH-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_src_i)
      3'b000:  imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      3'b001:  imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      3'b010:  imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      3'b011:  imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
      3'b100:  imm32 = {instr_i[31:12], 12'b0};
      default: imm32 = '0;
    endcase
    // Size cast of a signed operand sign-extends for DATA_WIDTH > 32.
    imm_o = DATA_WIDTH'($signed(imm32));
  end

endmodule

// ---------------------------------------------------------------------------
// control_unit -- main + ALU decoder.
//   opcode_i, funct3_i, funct7b5_i : instruction fields
//   alu_zero_i    : ALU zero flag (only feeds the redirect hint)
//   reg_write_o   : instruction writes rd
//   mem_write_o   : store
//   branch_o      : conditional branch
//   jump_o        : JAL / JALR
//   result_src_o  : 00 ALU, 01 memory, 10 PC+4, 11 immediate (LUI)
//   pc_target_src_o : 00 PC+imm, 01 rs1+imm (JALR)
//   mem_size_o    : 00 byte, 01 half, 10 word
//   alu_control_o : {funct7b5, funct3}-style op code, see localparams
//   alu_src_a_o   : 0 rs1, 1 PC
//   alu_src_b_o   : 0 rs2, 1 immediate
//   mem_unsigned_o: zero-extending load
//   imm_src_o     : immediate format for sign_extend
//   pc_src_o      : redirect hint (jump, or branch resolved on alu_zero)
// ---------------------------------------------------------------------------
module control_unit (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       alu_zero_i,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       branch_o,
  output logic       jump_o,
  output logic [1:0] result_src_o,
  output logic [1:0] pc_target_src_o,
  output logic [1:0] mem_size_o,
  output logic [3:0] alu_control_o,
  output logic       alu_src_a_o,
  output logic       alu_src_b_o,
  output logic       mem_unsigned_o,
  output logic [2:0] imm_src_o,
  output logic       pc_src_o
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b1000;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  always_comb begin
    reg_write_o     = 1'b0;
    mem_write_o     = 1'b0;
    branch_o        = 1'b0;
    jump_o          = 1'b0;
    result_src_o    = 2'b00;
    pc_target_src_o = 2'b00;
    mem_size_o      = 2'b00;
    alu_control_o   = ALU_ADD;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 1'b0;
    mem_unsigned_o  = 1'b0;
    imm_src_o       = IMM_I;
    case (opcode_i)
      OP_LOAD: begin
        reg_write_o    = 1'b1;
        result_src_o   = 2'b01;
        alu_src_b_o    = 1'b1;
        mem_size_o     = funct3_i[1:0];
        mem_unsigned_o = funct3_i[2];
      end
      OP_STORE: begin
        mem_write_o = 1'b1;
        alu_src_b_o = 1'b1;
        mem_size_o  = funct3_i[1:0];
        imm_src_o   = IMM_S;
      end
      OP_REG: begin
        reg_write_o = 1'b1;
        // funct7[5] only distinguishes SUB/ADD and SRA/SRL.
        alu_control_o = {funct7b5_i & (funct3_i == 3'b000 || funct3_i == 3'b101),
                         funct3_i};
      end
      OP_IMM: begin
        reg_write_o = 1'b1;
        alu_src_b_o = 1'b1;
        // Bit 30 is immediate data except for SRAI.
        alu_control_o = {funct7b5_i & (funct3_i == 3'b101), funct3_i};
      end
      OP_BRANCH: begin
        branch_o  = 1'b1;
        imm_src_o = IMM_B;
        case (funct3_i[2:1])
          2'b10:   alu_control_o = ALU_SLT;
          2'b11:   alu_control_o = ALU_SLTU;
          default: alu_control_o = ALU_SUB;
        endcase
      end
      OP_JAL: begin
        reg_write_o  = 1'b1;
        jump_o       = 1'b1;
        result_src_o = 2'b10;
        imm_src_o    = IMM_J;
      end
      OP_JALR: begin
        reg_write_o     = 1'b1;
        jump_o          = 1'b1;
        result_src_o    = 2'b10;
        pc_target_src_o = 2'b01;
        alu_src_b_o     = 1'b1;
      end
      OP_LUI: begin
        reg_write_o  = 1'b1;
        result_src_o = 2'b11;
        imm_src_o    = IMM_U;
      end
      OP_AUIPC: begin
        reg_write_o = 1'b1;
        alu_src_a_o = 1'b1;
        alu_src_b_o = 1'b1;
        imm_src_o   = IMM_U;
      end
      default: ;  // FENCE/SYSTEM/unknown decode as no-ops
    endcase
    // funct3[0] inverts the sense for BNE/BGE/BGEU.
    pc_src_o = jump_o | (branch_o & (alu_zero_i ^ funct3_i[0]));
  end

endmodule

// ---------------------------------------------------------------------------
// decode_pipe -- top of the decode stage (see file header for ports).
// REG_COUNT must be 16 (RV32E) or 32.
// ---------------------------------------------------------------------------
module decode_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [31:0]           if_instr,
  input  logic [DATA_WIDTH-1:0] if_pc,
  input  logic                  ex_stall,
  input  logic                  ex_flush,
  input  logic                  wb_en,
  input  logic [4:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  hazard_stall,
  output logic                  id_valid,
  output logic [DATA_WIDTH-1:0] id_pc,
  output logic [4:0]            id_rs1,
  output logic [4:0]            id_rs2,
  output logic [4:0]            id_rd,
  output logic [DATA_WIDTH-1:0] id_rs1_data,
  output logic [DATA_WIDTH-1:0] id_rs2_data,
  output logic [DATA_WIDTH-1:0] id_imm,
  output logic [2:0]            id_funct3,
  output logic                  id_reg_write,
  output logic                  id_mem_write,
  output logic                  id_branch,
  output logic                  id_jump,
  output logic [1:0]            id_result_src,
  output logic [1:0]            id_pc_target_src,
  output logic [1:0]            id_mem_size,
  output logic [3:0]            id_alu_control,
  output logic                  id_alu_src_a,
  output logic                  id_alu_src_b,
  output logic                  id_mem_unsigned
);

  localparam int         AW        = (REG_COUNT > 16) ? 5 : 4;
  localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);

  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] pc;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [2:0]            funct3;
    logic                  reg_write;
    logic                  mem_write;
    logic                  branch;
    logic                  jump;
    logic [1:0]            result_src;
    logic [1:0]            pc_target_src;
    logic [1:0]            mem_size;
    logic [3:0]            alu_control;
    logic                  alu_src_a;
    logic                  alu_src_b;
    logic                  mem_unsigned;
  } idex_t;

  // ---------------------------------------------------------------- fields
  logic [6:0] opcode;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;

  assign opcode  = if_instr[6:0];
  assign rs1_idx = if_instr[19:15];
  assign rs2_idx = if_instr[24:20];

  // --------------------------------------------------------- register file
  // x0 is not stored; entries 1..REG_COUNT-1 only.
  logic [DATA_WIDTH-1:0] rf_q [1:REG_COUNT-1];
  logic                  wb_ok;

  // Writes to x0 or beyond the implemented register count are dropped.
  assign wb_ok = wb_en && (wb_addr != 5'd0) && ({1'b0, wb_addr} < REG_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_ok) begin
      rf_q[wb_addr[AW-1:0]] <= wb_data;
    end
  end

  // Read port with write-through: a same-cycle write-back to the index
  // being read is forwarded so ID/EX captures the new value.
  function automatic logic [DATA_WIDTH-1:0] rf_read(input logic [4:0] idx);
    logic [DATA_WIDTH-1:0] val;
    val = '0;
    if (idx != 5'd0 && {1'b0, idx} < REG_LIMIT) begin
      if (wb_ok && wb_addr == idx) begin
        val = wb_data;
      end else begin
        val = rf_q[idx[AW-1:0]];
      end
    end
    return val;
  endfunction

  logic [DATA_WIDTH-1:0] rs1_rd_data;
  logic [DATA_WIDTH-1:0] rs2_rd_data;

  always_comb begin
    rs1_rd_data = rf_read(rs1_idx);
    rs2_rd_data = rf_read(rs2_idx);
  end

  // ---------------------------------------------------------------- decode
  logic                  cu_reg_write;
  logic                  cu_mem_write;
  logic                  cu_branch;
  logic                  cu_jump;
  logic [1:0]            cu_result_src;
  logic [1:0]            cu_pc_target_src;
  logic [1:0]            cu_mem_size;
  logic [3:0]            cu_alu_control;
  logic                  cu_alu_src_a;
  logic                  cu_alu_src_b;
  logic                  cu_mem_unsigned;
  logic [2:0]            cu_imm_src;
  logic                  unused_pc_src;
  logic [DATA_WIDTH-1:0] ext_imm;

  // Branches resolve in execute, so the zero flag is tied off here and the
  // redirect hint is not consumed.
  control_unit u_control_unit (
    .opcode_i        (opcode),
    .funct3_i        (if_instr[14:12]),
    .funct7b5_i      (if_instr[30]),
    .alu_zero_i      (1'b0),
    .reg_write_o     (cu_reg_write),
    .mem_write_o     (cu_mem_write),
    .branch_o        (cu_branch),
    .jump_o          (cu_jump),
    .result_src_o    (cu_result_src),
    .pc_target_src_o (cu_pc_target_src),
    .mem_size_o      (cu_mem_size),
    .alu_control_o   (cu_alu_control),
    .alu_src_a_o     (cu_alu_src_a),
    .alu_src_b_o     (cu_alu_src_b),
    .mem_unsigned_o  (cu_mem_unsigned),
    .imm_src_o       (cu_imm_src),
    .pc_src_o        (unused_pc_src)
  );

  sign_extend #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sign_extend (
    .instr_i   (if_instr[31:7]),
    .imm_src_i (cu_imm_src),
    .imm_o     (ext_imm)
  );

  idex_t dec;

  always_comb begin
    dec          = '0;
    dec.valid    = if_valid;
    dec.pc       = if_pc;
    dec.rs1      = rs1_idx;
    dec.rs2      = rs2_idx;
    dec.rd       = if_instr[11:7];
    dec.rs1_data = rs1_rd_data;
    dec.rs2_data = rs2_rd_data;
    dec.imm      = ext_imm;
    dec.funct3   = if_instr[14:12];
    // Control only for a real instruction: an empty IF/ID must not
    // produce a stray register write or store downstream.
    if (if_valid) begin
      dec.reg_write     = cu_reg_write;
      dec.mem_write     = cu_mem_write;
      dec.branch        = cu_branch;
      dec.jump          = cu_jump;
      dec.result_src    = cu_result_src;
      dec.pc_target_src = cu_pc_target_src;
      dec.mem_size      = cu_mem_size;
      dec.alu_control   = cu_alu_control;
      dec.alu_src_a     = cu_alu_src_a;
      dec.alu_src_b     = cu_alu_src_b;
      dec.mem_unsigned  = cu_mem_unsigned;
    end
  end

  // ------------------------------------------------------ load-use hazard
  idex_t idex_q;
  idex_t idex_d;
  logic  rs1_used;
  logic  rs2_used;
  logic  load_in_ex;
  logic  hazard_raw;

  // The rs2 field is immediate data outside R/S/B; rs1 is immediate data
  // for U-type and JAL.
  assign rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign rs2_used = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  assign load_in_ex = idex_q.valid && idex_q.reg_write &&
                      (idex_q.result_src == 2'b01) && (idex_q.rd != 5'd0);

  assign hazard_raw = if_valid && load_in_ex &&
                      ((rs1_used && idex_q.rd == rs1_idx) ||
                       (rs2_used && idex_q.rd == rs2_idx));

  // While execute is holding or flushing, the load is not advancing, so the
  // stall would be meaningless (stall) or wrong (flush kills the load).
  assign hazard_stall = hazard_raw && !ex_stall && !ex_flush;

  // ------------------------------------------------------------ ID/EX reg
  always_comb begin
    idex_d = idex_q;
    if (ex_flush) begin
      idex_d = '0;
    end else if (ex_stall) begin
      idex_d = idex_q;
    end else if (hazard_stall) begin
      idex_d = '0;
    end else begin
      idex_d = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign id_valid         = idex_q.valid;
  assign id_pc            = idex_q.pc;
  assign id_rs1           = idex_q.rs1;
  assign id_rs2           = idex_q.rs2;
  assign id_rd            = idex_q.rd;
  assign id_rs1_data      = idex_q.rs1_data;
  assign id_rs2_data      = idex_q.rs2_data;
  assign id_imm           = idex_q.imm;
  assign id_funct3        = idex_q.funct3;
  assign id_reg_write     = idex_q.reg_write;
  assign id_mem_write     = idex_q.mem_write;
  assign id_branch        = idex_q.branch;
  assign id_jump          = idex_q.jump;
  assign id_result_src    = idex_q.result_src;
  assign id_pc_target_src = idex_q.pc_target_src;
  assign id_mem_size      = idex_q.mem_size;
  assign id_alu_control   = idex_q.alu_control;
  assign id_alu_src_a     = idex_q.alu_src_a;
  assign id_alu_src_b     = idex_q.alu_src_b;
  assign id_mem_unsigned  = idex_q.mem_unsigned;

endmodule
